inference_ctrl: RTL and testbench

INFERENCE_CTRL -- requirements
Module: inference_ctrl

---
 rtl/inference_ctrl_if.sv | 29 ++
 rtl/inference_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_inference_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inference_ctrl_if.sv
// Handshake bundle between inference_ctrl and its receivers, CNN core, score RAM and byte transmitter.
interface inference_ctrl_if;
    logic        weight_rx_ready;
    logic        image_rx_ready;
    logic [7:0]  cmd_rx_data;
    logic        cmd_rx_ready;
    logic        cnn_start;
    logic        cnn_done;
    logic [3:0]  predicted_digit;
    logic [3:0]  score_addr;
    logic [31:0] score_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        weights_loaded;
    logic        overrun;

    modport slave (
        input  weight_rx_ready, image_rx_ready, cmd_rx_data, cmd_rx_ready,
        input  cnn_done, predicted_digit, score_data, tx_busy,
        output cnn_start, score_addr, tx_data, tx_start, weights_loaded, overrun
    );

    modport master (
        output weight_rx_ready, image_rx_ready, cmd_rx_data, cmd_rx_ready,
        output cnn_done, predicted_digit, score_data, tx_busy,
        input  cnn_start, score_addr, tx_data, tx_start, weights_loaded, overrun
    );
endinterface

// File: rtl/inference_ctrl.sv
// Sequencer for weight load, image load, CNN launch and result readout over a byte transmitter.
// Define INF_AUTO_SEND_EN to transmit the predicted digit automatically when inference completes.
module inference_ctrl #(
    parameter int WEIGHT_BEATS = 12985,
    parameter int IMAGE_BEATS  = 786,
    parameter int NUM_CLASSES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    inference_ctrl_if.slave  bus
);

    localparam logic [15:0] LP_WEIGHT_BEATS = 16'(WEIGHT_BEATS);
    localparam logic [15:0] LP_IMAGE_BEATS  = 16'(IMAGE_BEATS);
    localparam logic [15:0] LP_SCORE_BYTES  = 16'(NUM_CLASSES * 4);
    localparam logic [7:0]  CMD_DIGIT       = 8'hCC;
    localparam logic [7:0]  CMD_SCORES      = 8'hCD;

    typedef enum logic [2:0] {LOAD_W, IDLE, LOAD_I, RUN, READY, TX} state_t;
    typedef enum logic [1:0] {PH_FETCH, PH_SEND, PH_HOLD, PH_WAIT} phase_t;

    state_t      r_state;
    phase_t      r_phase;
    logic [15:0] r_weight_cnt;
    logic [15:0] r_image_cnt;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_byte_total;
    logic        r_score_mode;
    logic [3:0]  r_digit;
    logic        r_weights_loaded;
    logic        r_overrun;
    logic        r_cnn_start;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic [3:0]  r_score_addr;

    logic [15:0] w_weight_next;
    logic [15:0] w_image_next;
    logic [7:0]  w_tx_byte;

    // Beat counters saturate instead of wrapping.
    assign w_weight_next = (r_weight_cnt == 16'hFFFF) ? r_weight_cnt : r_weight_cnt + 16'd1;
    assign w_image_next  = (r_image_cnt  == 16'hFFFF) ? r_image_cnt  : r_image_cnt  + 16'd1;

    assign bus.cnn_start      = r_cnn_start;
    assign bus.tx_start       = r_tx_start;
    assign bus.tx_data        = r_tx_data;
    assign bus.score_addr     = r_score_addr;
    assign bus.weights_loaded = r_weights_loaded;
    assign bus.overrun        = r_overrun;

    // Scores go out little-endian; the RAM word stays valid while score_addr is held.
    always_comb begin
        w_tx_byte = 8'h00;
        if (!r_score_mode) begin
            w_tx_byte = {4'h0, r_digit};
        end else begin
            case (r_byte_cnt[1:0])
                2'd0: w_tx_byte = bus.score_data[7:0];
                2'd1: w_tx_byte = bus.score_data[15:8];
                2'd2: w_tx_byte = bus.score_data[23:16];
                default: w_tx_byte = bus.score_data[31:24];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= LOAD_W;
            r_phase          <= PH_SEND;
            r_weight_cnt     <= 16'd0;
            r_image_cnt      <= 16'd0;
            r_byte_cnt       <= 16'd0;
            r_byte_total     <= 16'd0;
            r_score_mode     <= 1'b0;
            r_digit          <= 4'd0;
            r_weights_loaded <= 1'b0;
            r_overrun        <= 1'b0;
            r_cnn_start      <= 1'b0;
            r_tx_start       <= 1'b0;
            r_tx_data        <= 8'h00;
            r_score_addr     <= 4'd0;
        end else begin
            r_cnn_start <= 1'b0;
            r_tx_start  <= 1'b0;
            if (bus.image_rx_ready && (r_state == RUN || r_state == TX)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                LOAD_W: begin
                    if (bus.weight_rx_ready) begin
                        r_weight_cnt <= w_weight_next;
                        if (w_weight_next == LP_WEIGHT_BEATS) begin
                            r_weights_loaded <= 1'b1;
                            r_state          <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (bus.image_rx_ready) begin
                        r_image_cnt <= 16'd1;
                        r_state     <= LOAD_I;
                    end
                end
                LOAD_I: begin
                    if (bus.image_rx_ready) begin
                        r_image_cnt <= w_image_next;
                        if (w_image_next == LP_IMAGE_BEATS) begin
                            r_cnn_start <= 1'b1;
                            r_state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.cnn_done) begin
                        r_digit <= bus.predicted_digit;
`ifdef INF_AUTO_SEND_EN
                        r_score_mode <= 1'b0;
                        r_byte_cnt   <= 16'd0;
                        r_byte_total <= 16'd1;
                        r_phase      <= PH_SEND;
                        r_state      <= TX;
`else
                        r_state <= READY;
`endif
                    end
                end
                READY: begin
                    if (bus.image_rx_ready) begin
                        r_image_cnt <= 16'd1;
                        r_state     <= LOAD_I;
                    end else if (bus.cmd_rx_ready && bus.cmd_rx_data == CMD_DIGIT) begin
                        r_score_mode <= 1'b0;
                        r_byte_cnt   <= 16'd0;
                        r_byte_total <= 16'd1;
                        r_phase      <= PH_SEND;
                        r_state      <= TX;
                    end else if (bus.cmd_rx_ready && bus.cmd_rx_data == CMD_SCORES) begin
                        r_score_mode <= 1'b1;
                        r_byte_cnt   <= 16'd0;
                        r_byte_total <= LP_SCORE_BYTES;
                        r_score_addr <= 4'd0;
                        r_phase      <= PH_FETCH;
                        r_state      <= TX;
                    end
                end
                TX: begin
                    // PH_HOLD skips the cycle where the transmitter has not yet raised busy.
                    case (r_phase)
                        PH_FETCH: r_phase <= PH_SEND;
                        PH_SEND: begin
                            if (!bus.tx_busy) begin
                                r_tx_start <= 1'b1;
                                r_tx_data  <= w_tx_byte;
                                r_phase    <= PH_HOLD;
                            end
                        end
                        PH_HOLD: r_phase <= PH_WAIT;
                        default: begin
                            if (!bus.tx_busy) begin
                                if (r_byte_cnt == r_byte_total - 16'd1) begin
                                    r_state <= READY;
                                end else begin
                                    r_byte_cnt <= r_byte_cnt + 16'd1;
                                    if (r_score_mode && r_byte_cnt[1:0] == 2'd3) begin
                                        r_score_addr <= r_score_addr + 4'd1;
                                        r_phase      <= PH_FETCH;
                                    end else begin
                                        r_phase <= PH_SEND;
                                    end
                                end
                            end
                        end
                    endcase
                end
                default: r_state <= LOAD_W;
            endcase
        end
    end

endmodule

// File: tb/tb_inference_ctrl.sv
// Directed bench for inference_ctrl: weight/image loading, digit and score readout, overrun and reset abort.
module tb_inference_ctrl;

    localparam int WB = 12985;
    localparam int IB = 786;
    localparam int NC = 10;

    logic clk;
    logic rst;
    inference_ctrl_if bus();

    inference_ctrl #(
        .WEIGHT_BEATS (WB),
        .IMAGE_BEATS  (IB),
        .NUM_CLASSES  (NC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int busyLen = 0;
    int busyLeft = 0;
    int startWhileBusy = 0;
    int dataChanged = 0;
    int cnnStartCount = 0;
    logic [7:0] heldByte = 8'h00;
    logic [7:0] txBytes[$];
    logic [31:0] scores [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Score RAM with one cycle of read latency.
    always @(posedge clk) bus.score_data <= scores[bus.score_addr];

    // Byte transmitter model: records bytes, holds busy, flags protocol violations.
    always @(negedge clk) begin
        if (bus.cnn_start) cnnStartCount++;
        if (bus.tx_start) begin
            if (bus.tx_busy) startWhileBusy++;
            txBytes.push_back(bus.tx_data);
            heldByte = bus.tx_data;
            if (busyLen > 0) begin
                bus.tx_busy = 1'b1;
                busyLeft = busyLen;
            end
        end else if (busyLeft > 0) begin
            if (bus.tx_data !== heldByte) dataChanged++;
            busyLeft--;
            if (busyLeft == 0) bus.tx_busy = 1'b0;
        end
    end

    task automatic pulseImage(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.image_rx_ready = 1'b1;
        end
        @(negedge clk);
        bus.image_rx_ready = 1'b0;
    endtask

    task automatic sendCmd(input logic [7:0] c);
        @(negedge clk);
        bus.cmd_rx_data  = c;
        bus.cmd_rx_ready = 1'b1;
        @(negedge clk);
        bus.cmd_rx_ready = 1'b0;
    endtask

    task automatic pulseDone(input logic [3:0] d);
        @(negedge clk);
        bus.predicted_digit = d;
        bus.cnn_done = 1'b1;
        @(negedge clk);
        bus.cnn_done = 1'b0;
    endtask

    task automatic waitForBytes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (txBytes.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.weights_loaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_weights_loaded: got %b expected 0", bus.weights_loaded); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
        checks++; if (bus.cnn_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnn_start: got %b expected 0", bus.cnn_start); end
        checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        checks++; if (bus.score_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_score_addr: got %h expected 0", bus.score_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ignored_in_load_w;
        sendCmd(8'hCC);
        pulseImage(3);
        pulseDone(4'd5);
        repeat (10) @(negedge clk);
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL loadw_image_no_overrun: got %b expected 0", bus.overrun); end
        checks++; if (txBytes.size() != 0) begin errors++; $display("[TB] FAIL loadw_cmd_ignored: got %0d bytes expected 0", txBytes.size()); end
        checks++; if (cnnStartCount != 0) begin errors++; $display("[TB] FAIL loadw_no_cnn_start: got %0d expected 0", cnnStartCount); end
    endtask

    task automatic test_weight_load;
        for (int i = 0; i < WB - 1; i++) begin
            @(negedge clk);
            bus.weight_rx_ready = 1'b1;
        end
        @(negedge clk);
        bus.weight_rx_ready = 1'b0;
        checks++; if (bus.weights_loaded !== 1'b0) begin errors++; $display("[TB] FAIL weights_before_last: got %b expected 0", bus.weights_loaded); end
        @(negedge clk);
        bus.weight_rx_ready = 1'b1;
        @(negedge clk);
        bus.weight_rx_ready = 1'b0;
        checks++; if (bus.weights_loaded !== 1'b1) begin errors++; $display("[TB] FAIL weights_after_last: got %b expected 1", bus.weights_loaded); end
        @(negedge clk);
        bus.weight_rx_ready = 1'b1;
        @(negedge clk);
        bus.weight_rx_ready = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.weights_loaded !== 1'b1) begin errors++; $display("[TB] FAIL weights_extra_pulse: got %b expected 1", bus.weights_loaded); end
        checks++; if (cnnStartCount != 0) begin errors++; $display("[TB] FAIL weights_no_cnn_start: got %0d expected 0", cnnStartCount); end
    endtask

    task automatic test_inference_digit;
        int base;
        bit ok;
        busyLen = 3;
        pulseImage(IB - 1);
        checks++; if (bus.cnn_start !== 1'b0 || cnnStartCount != 0) begin errors++; $display("[TB] FAIL start_early: got %b/%0d expected 0/0", bus.cnn_start, cnnStartCount); end
        pulseImage(1);
        checks++; if (bus.cnn_start !== 1'b1) begin errors++; $display("[TB] FAIL start_after_last_beat: got %b expected 1", bus.cnn_start); end
        base = txBytes.size();
        sendCmd(8'hCC);
        repeat (20) @(negedge clk);
        checks++; if (cnnStartCount != 1) begin errors++; $display("[TB] FAIL start_single_pulse: got %0d expected 1", cnnStartCount); end
        checks++; if (txBytes.size() != base) begin errors++; $display("[TB] FAIL run_cmd_ignored: got %0d bytes expected %0d", txBytes.size(), base); end
        pulseDone(4'd7);
`ifdef INF_AUTO_SEND_EN
        waitForBytes(base + 1, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL auto_digit_timeout: got %0d bytes expected %0d", txBytes.size(), base + 1); end
        else begin
            checks++; if (txBytes[base] !== 8'h07) begin errors++; $display("[TB] FAIL auto_digit_byte: got %h expected 07", txBytes[base]); end
        end
        repeat (10) @(negedge clk);
        base = txBytes.size();
`else
        repeat (10) @(negedge clk);
        checks++; if (txBytes.size() != base) begin errors++; $display("[TB] FAIL no_auto_send: got %0d bytes expected %0d", txBytes.size(), base); end
`endif
        sendCmd(8'hCC);
        waitForBytes(base + 1, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL digit_timeout: got %0d bytes expected %0d", txBytes.size(), base + 1); end
        else begin
            checks++; if (txBytes[base] !== 8'h07) begin errors++; $display("[TB] FAIL digit_byte: got %h expected 07", txBytes[base]); end
        end
        repeat (20) @(negedge clk);
        sendCmd(8'h55);
        repeat (20) @(negedge clk);
        checks++; if (txBytes.size() != base + 1) begin errors++; $display("[TB] FAIL digit_single_byte: got %0d bytes expected %0d", txBytes.size(), base + 1); end
    endtask

    task automatic test_scores;
        int base;
        bit ok;
        logic [31:0] word;
        logic [7:0] expect8;
        busyLen = 100;
        base = txBytes.size();
        sendCmd(8'hCD);
        waitForBytes(base + 4 * NC, 4 * NC * 120, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL scores_timeout: got %0d bytes expected %0d", txBytes.size() - base, 4 * NC); end
        repeat (150) @(negedge clk);
        checks++; if (txBytes.size() != base + 4 * NC) begin errors++; $display("[TB] FAIL scores_count: got %0d expected %0d", txBytes.size() - base, 4 * NC); end
        if (txBytes.size() >= base + 4 * NC) begin
            for (int j = 0; j < 4 * NC; j++) begin
                word = 32'(j / 4) * 32'h01020304;
                expect8 = word[8 * (j % 4) +: 8];
                checks++; if (txBytes[base + j] !== expect8) begin errors++; $display("[TB] FAIL scores_byte%0d: got %h expected %h", j, txBytes[base + j], expect8); end
            end
            checks++; if (txBytes[base + 4] !== 8'h04 || txBytes[base + 7] !== 8'h01) begin errors++; $display("[TB] FAIL scores_second_word: got %h..%h expected 04..01", txBytes[base + 4], txBytes[base + 7]); end
        end
        checks++; if (startWhileBusy != 0) begin errors++; $display("[TB] FAIL start_while_busy: got %0d expected 0", startWhileBusy); end
        checks++; if (dataChanged != 0) begin errors++; $display("[TB] FAIL tx_data_stable: got %0d changes expected 0", dataChanged); end
    endtask

    task automatic test_back_to_back;
        int base;
        int startBase;
        bit ok;
        busyLen = 1;
        startBase = cnnStartCount;
        pulseImage(400);
        pulseDone(4'd9);
        pulseImage(IB - 400);
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_before_run: got %b expected 0", bus.overrun); end
        pulseImage(1);
        repeat (10) @(negedge clk);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_in_run: got %b expected 1", bus.overrun); end
        checks++; if (cnnStartCount != startBase + 1) begin errors++; $display("[TB] FAIL b2b_cnn_start: got %0d expected %0d", cnnStartCount - startBase, 1); end
        base = txBytes.size();
        pulseDone(4'd3);
`ifdef INF_AUTO_SEND_EN
        waitForBytes(base + 1, 100, ok);
        checks++; if (!ok || txBytes[base] !== 8'h03) begin errors++; $display("[TB] FAIL auto_digit3: got %0d bytes expected 03", txBytes.size() - base); end
        repeat (10) @(negedge clk);
        base = txBytes.size();
`endif
        sendCmd(8'hCC);
        waitForBytes(base + 1, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d bytes expected %0d", txBytes.size(), base + 1); end
        else begin
            checks++; if (txBytes[base] !== 8'h03) begin errors++; $display("[TB] FAIL b2b_digit: got %h expected 03", txBytes[base]); end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_tx;
        int base;
        bit ok;
        busyLen = 100;
        base = txBytes.size();
        sendCmd(8'hCD);
        waitForBytes(base + 2, 400, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL midtx_timeout: got %0d bytes expected 2", txBytes.size() - base); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.weights_loaded !== 1'b0) begin errors++; $display("[TB] FAIL midtx_weights_loaded: got %b expected 0", bus.weights_loaded); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL midtx_overrun: got %b expected 0", bus.overrun); end
        @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        checks++; if (txBytes.size() != base + 2) begin errors++; $display("[TB] FAIL midtx_no_more_bytes: got %0d expected 2", txBytes.size() - base); end
        checks++; if (bus.tx_start !== 1'b0 || bus.score_addr !== 4'h0) begin errors++; $display("[TB] FAIL midtx_idle_outputs: got %b/%h expected 0/0", bus.tx_start, bus.score_addr); end
    endtask

    initial begin
        rst = 1'b1;
        bus.weight_rx_ready = 1'b0;
        bus.image_rx_ready  = 1'b0;
        bus.cmd_rx_data     = 8'h00;
        bus.cmd_rx_ready    = 1'b0;
        bus.cnn_done        = 1'b0;
        bus.predicted_digit = 4'h0;
        bus.tx_busy         = 1'b0;
        for (int k = 0; k < 16; k++) scores[k] = (k < NC) ? 32'(k) * 32'h01020304 : 32'h0;
        test_reset;
        test_ignored_in_load_w;
        test_weight_load;
        test_inference_digit;
        test_scores;
        test_back_to_back;
        test_reset_mid_tx;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
